// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode field, stop/bubble encodings,
// fetch FSM state codes and the fetch skid entry.
package pipe_pkg;

   localparam logic [3:0] STOP_OP  = 4'b0001;
   localparam logic [7:0] NOP_INSN = 8'h00;
   localparam int         OP_HI    = 3;
   localparam int         OP_LO    = 0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   typedef struct packed {
      logic [7:0] insn;
      logic [7:0] pc;
   } fetch_ent_t;

   function automatic logic is_stop(
      input logic [7:0] insn,
      input logic [3:0] op
   );
      return insn[OP_HI:OP_LO] == op;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for an instruction returned while the
// downstream stage is stalled.
module fetch_skid_buf (
   input  logic       clock,
   input  logic       reset,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] push_insn,
   input  logic [7:0] push_pc,
   output logic       full,
   output logic [7:0] insn,
   output logic [7:0] pc
);
   import pipe_pkg::*;

   fetch_ent_t ent;

   always_ff @(posedge clock) begin
      if (!reset || flush) begin
         full <= 1'b0;
      end else if (push) begin
         full <= 1'b1;
         ent  <= '{insn: push_insn, pc: push_pc};
      end else if (pop) begin
         full <= 1'b0;
      end
   end

   assign insn = ent.insn;
   assign pc   = ent.pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: request/ack memory handshake, skid buffer
// for stalls, redirect flush and stop-instruction halt.
module fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter logic [7:0] NOP_INSN = pipe_pkg::NOP_INSN,
   parameter logic [3:0] STOP_OP  = pipe_pkg::STOP_OP
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       en_fetch,
   input  logic       stall,
   input  logic       redirect,
   input  logic [7:0] redirect_pc,
   output logic       imem_req,
   output logic [7:0] imem_addr,
   input  logic       imem_ack,
   input  logic [7:0] imem_data,
   output logic [7:0] ir1,
   output logic [7:0] pc1,
   output logic       ir1_valid,
   output logic       halted
);
   import pipe_pkg::*;

   logic [1:0] state;
   logic [7:0] pc;
   logic       drop;
   logic       ack_ok;
   logic       skid_full;
   logic [7:0] skid_insn;
   logic [7:0] skid_pc;

   // drop marks an in-flight request whose data a redirect made stale
   assign ack_ok   = (state == S_REQ) && imem_ack && !drop;
   assign imem_req = (state == S_REQ);

   fetch_skid_buf u_skid (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect),
      .push      (!redirect && ack_ok && stall),
      .pop       (!redirect && !stall && skid_full),
      .push_insn (imem_data),
      .push_pc   (imem_addr),
      .full      (skid_full),
      .insn      (skid_insn),
      .pc        (skid_pc)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         imem_addr <= RESET_PC;
         drop      <= 1'b0;
         ir1       <= NOP_INSN;
         pc1       <= 8'h00;
         ir1_valid <= 1'b0;
         halted    <= 1'b0;
      end else if (redirect) begin
         pc        <= redirect_pc;
         ir1       <= NOP_INSN;
         ir1_valid <= 1'b0;
         halted    <= 1'b0;
         if (state == S_REQ && !imem_ack) begin
            drop <= 1'b1;
         end else begin
            drop      <= 1'b0;
            state     <= S_REQ;
            imem_addr <= redirect_pc;
         end
      end else begin
         if (!stall) begin
            unique case (1'b1)
               skid_full: begin
                  ir1       <= skid_insn;
                  pc1       <= skid_pc;
                  ir1_valid <= 1'b1;
               end
               ack_ok: begin
                  ir1       <= imem_data;
                  pc1       <= imem_addr;
                  ir1_valid <= 1'b1;
               end
               default: begin
                  ir1       <= NOP_INSN;
                  ir1_valid <= 1'b0;
               end
            endcase
         end
         unique case (state)
            S_IDLE: begin
               if (en_fetch && !skid_full) begin
                  state     <= S_REQ;
                  imem_addr <= pc;
               end
            end
            S_REQ: begin
               if (imem_ack && drop) begin
                  drop      <= 1'b0;
                  imem_addr <= pc;
               end else if (imem_ack) begin
                  pc <= pc + 8'd1;
                  // a stalled ack fills the skid, so fall back to idle
                  if (is_stop(imem_data, STOP_OP)) begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                  end else if (en_fetch && !stall) begin
                     imem_addr <= pc + 8'd1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_HALT: ;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then random
// stall/redirect/ack traffic checked against a queue-based model.
module tb_fetch_unit;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       en_fetch = 1'b0;
   logic       stall = 1'b0;
   logic       redirect = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic       imem_ack = 1'b0;
   logic [7:0] imem_data = 8'h00;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic [7:0] ir1;
   logic [7:0] pc1;
   logic       ir1_valid;
   logic       halted;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [256];
   int         lat = 0;
   bit         rnd_ack = 1'b0;
   int         wait_cnt = 0;

   typedef struct {
      logic [7:0] insn;
      logic [7:0] pc;
   } exp_t;

   exp_t       q[$];
   logic [7:0] mpc = 8'h00;
   bit         mhalt = 1'b0;
   bit         mdrop = 1'b0;
   bit         e_rst = 1'b0;
   bit         e_redir = 1'b0;
   bit         e_stall = 1'b0;
   bit         p_req = 1'b0;
   bit         p_ack = 1'b0;
   logic [7:0] p_addr = 8'h00;

   fetch_unit dut (
      .clock       (clock),
      .reset       (reset),
      .en_fetch    (en_fetch),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .ir1         (ir1),
      .pc1         (pc1),
      .ir1_valid   (ir1_valid),
      .halted      (halted)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   // memory: fixed latency or random acks, data from mem[]
   always @(negedge clock) begin
      if (rnd_ack)
         imem_ack = imem_req && ($urandom % 3 != 0);
      else
         imem_ack = imem_req && (wait_cnt >= lat);
      imem_data = mem[imem_addr];
   end

   // reference model: what fetch should have accepted, in order
   always @(posedge clock) begin
      e_rst   = reset;
      e_redir = redirect;
      e_stall = stall;
      p_req   = imem_req;
      p_ack   = imem_ack;
      p_addr  = imem_addr;
      if (!reset) begin
         q.delete();
         mpc   = 8'h00;
         mhalt = 1'b0;
         mdrop = 1'b0;
      end else if (redirect) begin
         q.delete();
         mdrop = imem_req && !imem_ack;
         mpc   = redirect_pc;
         mhalt = 1'b0;
      end else if (imem_req && imem_ack) begin
         if (mdrop) begin
            mdrop = 1'b0;
         end else begin
            chk("req_addr", imem_addr, mpc);
            q.push_back('{insn: imem_data, pc: mpc});
            mpc = mpc + 8'd1;
            if (imem_data[3:0] == 4'b0001) mhalt = 1'b1;
         end
      end
      if (imem_req && !imem_ack) wait_cnt++;
      else wait_cnt = 0;
   end

   // monitor: compare ir1 after every edge that could load it
   always @(negedge clock) begin
      exp_t e;
      if (e_rst) begin
         if (e_redir) begin
            chk("flush_valid", ir1_valid, 0);
            chk("flush_ir1", ir1, 8'h00);
         end else if (!e_stall) begin
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("ir1", ir1, e.insn);
               chk("pc1", pc1, e.pc);
               chk("ir1_valid", ir1_valid, 1);
            end else begin
               chk("bubble_valid", ir1_valid, 0);
               chk("bubble_ir1", ir1, 8'h00);
            end
         end
         if (q.size() > 0) chk("skid_noreq", imem_req, 0);
         chk("halted", halted, mhalt);
         if (mhalt) chk("halt_noreq", imem_req, 0);
         if (p_req && !p_ack) begin
            chk("hold_req", imem_req, 1);
            chk("hold_addr", imem_addr, p_addr);
         end
      end
   end

   initial begin
      logic [7:0] b;
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom);
         if (b[3:0] == 4'b0001) b[3:0] = 4'b0010;
         mem[i] = b;
      end
      mem[0] = 8'h12;
      mem[1] = 8'h34;
      mem[2] = 8'h56;
      mem[3] = 8'h78;
      mem[5] = 8'h9A;
      mem[7] = 8'h21;

      step();
      step();
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 8'h00);
      chk("rst_ir1", ir1, 8'h00);
      chk("rst_pc1", pc1, 8'h00);
      chk("rst_valid", ir1_valid, 0);
      chk("rst_halted", halted, 0);
      reset = 1'b1;
      en_fetch = 1'b1;

      step();
      chk("f0_req", imem_req, 1);
      chk("f0_addr", imem_addr, 8'h00);
      step();
      chk("f0_ir1", ir1, 8'h12);
      chk("f0_pc1", pc1, 8'h00);
      chk("f1_addr", imem_addr, 8'h01);
      step();
      chk("f1_ir1", ir1, 8'h34);
      chk("f2_addr", imem_addr, 8'h02);
      step();
      chk("f2_ir1", ir1, 8'h56);
      chk("f2_pc1", pc1, 8'h02);
      chk("f3_addr", imem_addr, 8'h03);
      stall = 1'b1;

      step();
      chk("st0_ir1", ir1, 8'h56);
      chk("st0_req", imem_req, 0);
      step();
      chk("st1_ir1", ir1, 8'h56);
      chk("st1_req", imem_req, 0);
      stall = 1'b0;
      step();
      chk("st_ir1", ir1, 8'h78);
      chk("st_pc1", pc1, 8'h03);
      step();
      chk("res_req", imem_req, 1);
      chk("res_addr", imem_addr, 8'h04);

      step();
      chk("rd_addr5", imem_addr, 8'h05);
      redirect = 1'b1;
      redirect_pc = 8'h40;
      step();
      redirect = 1'b0;
      chk("rd_ir1", ir1, 8'h00);
      chk("rd_valid", ir1_valid, 0);
      chk("rd_addr", imem_addr, 8'h40);
      chk("rd_req", imem_req, 1);

      step();
      redirect = 1'b1;
      redirect_pc = 8'h07;
      step();
      redirect = 1'b0;
      chk("h_addr", imem_addr, 8'h07);
      step();
      chk("h_ir1", ir1, 8'h21);
      chk("h_pc1", pc1, 8'h07);
      chk("h_halted", halted, 1);
      lat = 3;
      for (int k = 0; k < 10; k++) begin
         chk("h_noreq", imem_req, 0);
         step();
      end
      redirect = 1'b1;
      redirect_pc = 8'h10;
      step();
      redirect = 1'b0;
      chk("h_unhalt", halted, 0);
      chk("h_raddr", imem_addr, 8'h10);
      chk("h_rreq", imem_req, 1);

      for (int k = 0; k < 10 && !imem_ack; k++) step();
      chk("ack10_seen", imem_ack, 1);
      redirect = 1'b1;
      redirect_pc = 8'hFF;
      step();
      redirect = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("ff_req", imem_req, 1);
         chk("ff_addr", imem_addr, 8'hFF);
         step();
      end
      chk("wrap_req", imem_req, 1);
      chk("wrap_addr", imem_addr, 8'h00);

      for (int k = 0; k < 12 && imem_addr != 8'h01; k++) step();
      chk("r_addr1", imem_addr, 8'h01);
      chk("r_req1", imem_req, 1);
      reset = 1'b0;
      step();
      chk("r_req", imem_req, 0);
      chk("r_ir1", ir1, 8'h00);
      chk("r_valid", ir1_valid, 0);
      chk("r_pc", imem_addr, 8'h00);
      reset = 1'b1;

      rnd_ack = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int c = 0; c < 3000; c++) begin
         step();
         stall       = ($urandom % 4 == 0);
         en_fetch    = ($urandom % 8 != 0);
         redirect    = ($urandom % 30 == 0);
         redirect_pc = 8'($urandom);
         reset       = ($urandom % 300 != 0);
      end
      reset = 1'b1;
      redirect = 1'b0;
      stall = 1'b0;
      step();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: RESET_PC, 8'h00, first fetch address; NOP_INSN, 8'h00, bubble loaded into ir1 on reset/flush; STOP_OP, 4'b0001, opcode field ir[3:0] of the stop instruction.
REQ-002 One clock, "clock"; reset is synchronous and active-low, port "reset".
REQ-003 Ports SHALL be (name direction width meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- en_fetch  in  1  fetch-stage enable from pipeline control
- stall  in  1  downstream cannot accept a new ir1 this cycle
- redirect  in  1  taken branch/jump from execute; flush and refetch
- redirect_pc  in  8  new fetch address when redirect=1
- imem_req  out  1  instruction-memory request, held until acknowledged
- imem_addr  out  8  request address
- imem_ack  in  1  memory returns data this cycle
- imem_data  in  8  instruction word, valid when imem_ack=1
- ir1  out  8  fetched instruction register
- pc1  out  8  address of the instruction in ir1
- ir1_valid  out  1  ir1 holds a real fetched instruction, not a bubble
- halted  out  1  stop instruction fetched; fetching has ceased

Function
REQ-004 FSM states SHALL be S_IDLE, S_REQ, S_HALT.
REQ-005 S_IDLE: imem_req=0; go to S_REQ when en_fetch=1 and the skid buffer is empty.
REQ-006 S_REQ: imem_req=1, imem_addr=pc; hold both stable until imem_ack=1; ack is legal in the first S_REQ cycle (zero wait states).
REQ-007 On ack with stall=0, no redirect: at that edge ir1<=imem_data, pc1<=pc, ir1_valid<=1, pc<=pc+1 mod 256 (8'hFF wraps to 8'h00).
REQ-008 On ack with stall=1: imem_data/pc go into the one-entry skid buffer and pc increments; no new request issues while the skid buffer is full.
REQ-009 When stall=0 and the skid buffer is full, the skid entry SHALL move into ir1/pc1 at the next edge; the buffer then empties.
REQ-010 While stall=1, ir1, pc1 and ir1_valid SHALL hold their values.
REQ-011 If no instruction is loaded in a cycle with stall=0, ir1<=NOP_INSN and ir1_valid<=0.
REQ-012 After an ack, go to S_REQ if en_fetch=1 and the skid buffer is empty, otherwise S_IDLE; sustained throughput with single-cycle ack is one instruction per clock.
REQ-013 en_fetch=0 SHALL block new requests only; an outstanding request stays asserted until acked.
REQ-014 Stop detection: when the accepted instruction has [3:0]==STOP_OP, it is delivered to ir1 normally, the FSM enters S_HALT, and halted<=1; S_HALT issues no requests.
REQ-015 redirect=1 SHALL override stall, ack and state: at that edge pc<=redirect_pc, ir1<=NOP_INSN, ir1_valid<=0, skid buffer cleared, halted<=0, and any same-cycle or in-flight ack data discarded.
REQ-016 After redirect, the FSM goes to S_REQ with imem_addr=redirect_pc. An outstanding request is first completed with its data dropped, and the new request issues in the cycle after that ack.
REQ-017 Redirect in S_HALT SHALL leave S_HALT, because the stop instruction was speculative.

Reset
REQ-018 reset=0 sampled at a rising edge SHALL set state=S_IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, ir1=NOP_INSN, pc1=8'h00, ir1_valid=0, halted=0, and skid buffer empty.
REQ-019 Reset asserted mid-request SHALL abandon the request; an imem_ack in the reset cycle is ignored.

Structure
REQ-020 A shared package pipe_pkg SHALL hold STOP_OP, NOP_INSN, the opcode field range [3:0], and the fetch-state encoding; all stages SHALL use it.
REQ-021 The skid buffer SHALL be the sub-module fetch_skid_buf (one entry of 8-bit insn + 8-bit pc, with push, pop, flush, full).

Verification
REQ-022 Reset then en_fetch=1, zero-wait memory returning 8'h12,8'h34,8'h56 -> imem_addr 00,01,02; ir1 12,34,56 on consecutive cycles; pc1 00,01,02; ir1_valid=1.
REQ-023 stall=1 in the cycle of ack for addr 03 (data 8'h78), held 2 cycles -> ir1 frozen at 56, no request for 04 issued, then ir1=78 with pc1=03, then fetch resumes at 04.
REQ-024 redirect=1 with redirect_pc=8'h40 in the same cycle as ack of 8'h9A -> 9A never appears in ir1, ir1=NOP with ir1_valid=0 next cycle, next imem_addr=40.
REQ-025 Fetch 8'h21 (opcode 0001) at addr 07 -> ir1=21, halted=1, imem_req stays 0 for 10 cycles; then redirect to 8'h10 -> halted=0, imem_addr=10.
REQ-026 pc at 8'hFF with 3-cycle ack latency -> imem_addr held at FF for all wait cycles; next request address is 00.
REQ-027 reset=0 asserted while imem_req=1 and ack pending -> next cycle imem_req=0, ir1=NOP, pc=RESET_PC.
